// File: rtl/grant_scheduler_pkg.sv
// grant_scheduler_pkg
//   Shared definitions for the grant scheduler: FSM state encoding,
//   requester count, index width, default hold limit and the
//   round-robin pick helper.
package grant_scheduler_pkg;

  localparam int N_REQ        = 4;
  localparam int IDX_W        = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set request bit scanning ptr, ptr+1, ... modulo N_REQ.
  // The scan runs from the farthest offset down so the nearest hit wins.
  // Returns ptr when no bit is set; callers only use it with req nonzero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    rr_pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) rr_pick = cand;
    end
  endfunction

endpackage

// File: rtl/grant_scheduler_dec.sv
// dec2to4_en
//   Combinational 2-to-4 one-hot decoder with enable. Output is all-zero
//   when en is low.
// Ports:
//   idx  in   2  binary index
//   en   in   1  enable
//   dec  out  4  one-hot decode of idx, or zero
module dec2to4_en
  import grant_scheduler_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[idx] = 1'b1;
  end

endmodule

// File: rtl/grant_scheduler.sv
// grant_scheduler
//   Round-robin single-owner grant scheduler for four requesters. An owner
//   keeps the grant while its request stays high; releasing moves the
//   priority pointer past it. A forced zero-grant cycle separates owners.
//   Optional feature macro: GRANT_TIMEOUT_EN -- limits a grant to MAX_HOLD
//   cycles and pulses timeout on forced release.
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   4  request per requester
//   gnt      out  4  one-hot grant, zero when no owner
//   gnt_idx  out  2  index of the owner, 0 when no owner
//   busy     out  1  high while a grant is active
//   timeout  out  1  one-cycle pulse on forced release
//
// state | meaning
// IDLE  | no owner; next cycle grants the round-robin pick if any req is set
// GRANT | gnt_idx owns the resource until its req drops (or hold limit hits)
module grant_scheduler
  import grant_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("grant_scheduler: MAX_HOLD must be in 2..255");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

`ifdef GRANT_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef GRANT_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = rr_pick(req, ptr_q);
`ifdef GRANT_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        // Voluntary release is tested first so it wins over a same-cycle
        // timeout and leaves the timeout pulse low.
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = idx_q + IDX_W'(1);
          idx_d   = '0;
`ifdef GRANT_TIMEOUT_EN
        end else if (hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          idx_d     = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy    = (state_q == GRANT);
  assign gnt_idx = idx_q;

`ifdef GRANT_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Decoder inputs are both register outputs, so gnt is glitch-free and
  // clears as soon as reset forces state_q to IDLE.
  dec2to4_en u_dec (
    .idx (idx_q),
    .en  (busy),
    .dec (gnt)
  );

endmodule

// File: tb/tb_grant_scheduler.sv
module tb_grant_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  grant_scheduler #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full grant view: gnt, gnt_idx, busy, timeout against expectations.
  task automatic chk_g(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                       input logic eb, input logic et);
    chk({tag, ".gnt"}, {4'd0, gnt}, {4'd0, eg});
    chk({tag, ".idx"}, {6'd0, gnt_idx}, {6'd0, ei});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
    chk({tag, ".tmo"}, {7'd0, timeout}, {7'd0, et});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every-cycle structural check on gnt.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert ((gnt & (gnt - 4'd1)) == 4'd0) else begin
        errors++;
        $error("FAIL onehot gnt=%b expected zero or one-hot", gnt);
      end
      if (busy) begin
        checks++;
        assert (gnt === (4'b0001 << gnt_idx)) else begin
          errors++;
          $error("FAIL decode gnt=%b expected=%b", gnt, 4'b0001 << gnt_idx);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    #12;
    chk_g("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 5; i++) begin
      step();
      chk_g("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    end

    // All requesting; each owner releases after two grant cycles.
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      automatic int k = n % 4;
      step();
      chk_g("rr_g1", 4'b0001 << k, 2'(k), 1'b1, 1'b0);
      step();
      chk_g("rr_g2", 4'b0001 << k, 2'(k), 1'b1, 1'b0);
      req[k] = 1'b0;
      step();
      chk_g("rr_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
      req[k] = 1'b1;
    end
    req = 4'b0000;
    step();
    chk_g("rr_end", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester 2, then pointer lands on 3.
    req = 4'b0100;
    step();
    chk_g("r2_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    chk_g("r2_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
    step();
    chk_g("r2_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_g("r2_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1001;
    step();
    chk_g("ptr3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_g("ptr3_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef GRANT_TIMEOUT_EN
    // Hold limit of 4 cycles alternates two persistent requesters.
    req = 4'b0011;
    step();
    chk_g("to_r0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_g("to_r0h", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    chk_g("to_p0", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk_g("to_r1", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_g("to_r1h", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step();
    chk_g("to_p1", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk_g("to_r0b", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_g("to_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Lone requester: timed out, re-granted after one gap cycle, then a
    // voluntary release on the last allowed cycle keeps timeout low.
    req = 4'b0001;
    step();
    chk_g("lone_g", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_g("lone_h", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    step();
    chk_g("lone_to", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk_g("lone_re", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_g("lone_h2", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    chk_g("tie_vol", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    // Without the hold limit a held request keeps the grant indefinitely.
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_g("nolimit", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    chk_g("nolimit_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    // Asynchronous reset during a grant to requester 2.
    req = 4'b0100;
    step();
    chk_g("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_g("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0101;
    @(posedge clk);
    #3;
    chk_g("in_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_g("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    chk_g("post_rel", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
